fpu_pack_pipe: RTL and testbench
================================

// Module: fpu_pack_pipe
// PURPOSE
// - Multi-lane, buffered FP result packer at the FPU writeback boundary. Accepts LANES FLEN-wide
//   results in internal (FLEN-format) layout via valid/ready, narrows each lane to the format
//   selected by Fmt, NaN-boxes or zero-extends to FLEN, and queues results in a DEPTH-entry FIFO.
// - Decouples FPU result timing from register-file/vector writeback stalls.
// PARAMETERS (FLEN, FMTBITS, FPSIZES, NE/NF, NE1/NF1, NE2/NF2, H_NE/H_NF, LEN1/LEN2/H_LEN from config_pkg)
// - LANES  1  parallel result lanes, all sharing one Fmt/BoxEn per beat
// - DEPTH  2  output FIFO entries; >=1; need not be a power of two
// PORTS
// - clk        in   1            clock, all state on rising edge
// - reset_n    in   1            asynchronous, active-low reset
// - Flush      in   1            synchronous FIFO clear (pipeline flush)
// - InValid    in   1            input beat valid
// - InReady    out  1            packer can accept a beat this cycle
// - Unpacked   in   LANES*FLEN   lane i = bits [i*FLEN +: FLEN], internal FLEN-format layout
// - Fmt        in   FMTBITS      RISC-V fmt: 00 single, 01 double, 10 half, 11 quad
// - BoxEn      in   1            1: fill upper bits with 1s (NaN-box); 0: fill with 0s
// - OutValid   out  1            FIFO head valid
// - OutReady   in   1            consumer takes head this cycle
// - Packed     out  LANES*FLEN   FIFO head data
// - FmtErr     out  1            head beat carried a format not enabled by FPSIZES
// BEHAVIOUR
// - Reset (reset_n=0, asynchronous): count=0, rd/wr pointers=0, OutValid=0, Packed=0, FmtErr=0,
//   FIFO storage=0. Any in-flight beat is discarded.
// - Per-lane narrowing to target format with exponent width E, fraction width F:
//   Exp = {U[FLEN-2], U[NF+E-2:NF]}; Frac = U[NF-1:NF-F]; Sign = U[FLEN-1];
//   lane = {{(FLEN-1-E-F){BoxEn}}, Sign, Exp, Frac}. Native FLEN format: lane = U, BoxEn ignored.
// - Format support: FPSIZES=1 only native; 2 adds FMT1; 3 adds FMT2; 4 = quad/double/single/half.
//   Unsupported Fmt: all lanes packed as 0, FmtErr=1 stored with that beat. No X on outputs.
// - Push = InValid & InReady & ~Flush. Pop = OutValid & OutReady.
// - InReady = ~Flush & ((count<DEPTH) | OutReady). Full FIFO with simultaneous pop accepts a push.
// - Latency: accepted beat appears on Packed/OutValid the cycle after acceptance; no
//   combinational bypass, even when empty.
// - Simultaneous push+pop: count unchanged, both pointers advance. Pointers wrap at DEPTH-1 -> 0.
// - Empty: OutValid=0, Packed/FmtErr hold last popped value (0 after reset). Pop ignored when empty.
// - Flush: next cycle count=0, pointers=0, OutValid=0; Flush overrides push and pop in same cycle.
// - Fmt/BoxEn/Unpacked sampled only on push; need not be held afterwards.
// - Consumer may drop OutReady any cycle; head stays stable until popped.
// CONFIGURATION
// - FPU_PACK_NANCANON_EN defined: after narrowing, any lane with Exp all-ones and Frac != 0 is
//   replaced by the canonical qNaN of that format (Sign=0, Exp=1s, Frac MSB=1, rest 0), then
//   filled per BoxEn. Applied to native format too. FmtErr unaffected.
// - Undefined: NaN payload and sign pass through narrowing unchanged (pure truncation).
// TESTING (FLEN=64, FPSIZES=3, LANES=2, DEPTH=2)
// - Single 1.0: lane0 U=0x3FF0000000000000, Fmt=00, BoxEn=1 -> Packed lane0=0xFFFFFFFF3F800000 next
//   cycle; BoxEn=0 -> 0x000000003F800000; Fmt=01 -> 0x3FF0000000000000 unchanged.
// - Backpressure: OutReady=0, 3 pushes -> only 2 accepted, InReady=0 on 3rd; then OutReady=1 with
//   InValid=1 -> pop+push same cycle, count stays 2, beats leave in order.
// - Fmt=10 (half, unsupported) -> lanes=0, FmtErr=1; next beat Fmt=00 -> FmtErr=0.
// - sNaN U=0xFFF4000000000000, Fmt=00, BoxEn=1 -> 0xFFFFFFFF7FC00000 with FPU_PACK_NANCANON_EN,
//   0xFFFFFFFFFFA00000 without.
// - Flush asserted with FIFO full and InValid=1 -> no push, next cycle OutValid=0, InReady=1.
// - reset_n low mid-stream (async, between edges) -> OutValid/Packed/FmtErr 0 immediately.

Source files
------------

// File: rtl/fpu_pack_pipe_if.sv
// fpu_pack_pipe_if: beat-in / packed-out handshake bundle between FPU writeback and the packer.
interface fpu_pack_pipe_if #(
  parameter int LANES = 1,
  parameter int FLEN  = 64
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*FLEN-1:0] unpacked;
  logic [1:0]            fmt;
  logic                  box_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*FLEN-1:0] pkd;
  logic                  fmt_err;
  modport master (
    output flush, in_valid, unpacked, fmt, box_en, out_ready,
    input  in_ready, out_valid, pkd, fmt_err
  );
  modport slave (
    input  flush, in_valid, unpacked, fmt, box_en, out_ready,
    output in_ready, out_valid, pkd, fmt_err
  );
endinterface

// File: rtl/fpu_pack_pipe.sv
// fpu_pack_pipe: narrows/NaN-boxes LANES FP results per beat and queues them in a DEPTH-entry FIFO.
// Optional FPU_PACK_NANCANON_EN replaces NaN lanes with the target format's canonical qNaN.
module fpu_pack_pipe #(
  parameter int FLEN    = 64,
  parameter int FPSIZES = 3,
  parameter int LANES   = 1,
  parameter int DEPTH   = 2
) (
  input logic            clk,
  input logic            reset_n,
  fpu_pack_pipe_if.slave bus
);
  localparam int NE = FLEN == 128 ? 15 : FLEN == 64 ? 11 : FLEN == 32 ? 8 : 5;
  localparam int NF = FLEN - 1 - NE;
  localparam int NI = FLEN == 128 ? 0 : FLEN == 64 ? 1 : FLEN == 32 ? 2 : 3;
  localparam int DW = LANES * FLEN;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [3:0]         sup;
  logic [3:0][DW-1:0] res;
  // k indexes formats widest first: quad, double, single, half
  for (genvar k = 0; k < 4; k++) begin : g_k
    localparam int E = k == 0 ? 15 : k == 1 ? 11 : k == 2 ? 8 : 5;
    localparam int F = k == 0 ? 112 : k == 1 ? 52 : k == 2 ? 23 : 10;
    localparam int W = 1 + E + F;
    assign sup[k] = (k >= NI) && (k < NI + FPSIZES) && (k != 3 || FPSIZES == 4 || NI == 3);
    for (genvar l = 0; l < LANES; l++) begin : g_l
      localparam int B = l * FLEN;
      if (W > FLEN) begin : g_none
        assign res[k][B +: FLEN] = '0;
      end else begin : g_fit
        logic         s, s2;
        logic [E-1:0] e;
        logic [F-1:0] f, f2;
        if (W == FLEN) begin : g_nat
          assign {s, e, f} = bus.unpacked[B +: FLEN];
        end else begin : g_nar
          assign s = bus.unpacked[B+FLEN-1];
          assign e = {bus.unpacked[B+FLEN-2], bus.unpacked[B+NF+E-2 : B+NF]};
          assign f = bus.unpacked[B+NF-1 : B+NF-F];
        end
`ifdef FPU_PACK_NANCANON_EN
        logic nan;
        assign nan = &e && |f;
        assign s2  = s & ~nan;
        assign f2  = nan ? {1'b1, {(F-1){1'b0}}} : f;
`else
        assign s2 = s;
        assign f2 = f;
`endif
        if (W == FLEN) begin : g_onat
          assign res[k][B +: FLEN] = {s2, e, f2};
        end else begin : g_onar
          assign res[k][B +: FLEN] = {{(FLEN-W){bus.box_en}}, s2, e, f2};
        end
      end
    end
  end
  logic [1:0]    ks;
  logic [DW:0]   wdat;
  logic [DW:0]   mem_q [DEPTH];
  logic [DW:0]   last_q;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  // RISC-V fmt code to width rank: 00->single, 01->double, 10->half, 11->quad
  assign ks   = {~bus.fmt[0], bus.fmt[1] ^ bus.fmt[0]};
  assign wdat = sup[ks] ? {1'b0, res[ks]} : {1'b1, {DW{1'b0}}};
  assign bus.in_ready  = ~bus.flush & ((cnt_q < CW'(DEPTH)) | bus.out_ready);
  assign bus.out_valid = cnt_q != '0;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;
  assign {bus.fmt_err, bus.pkd} = bus.out_valid ? mem_q[rd_q] : last_q;
  always_comb begin
    wr_d  = bus.flush ? '0 : !push ? wr_q : wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1;
    rd_d  = bus.flush ? '0 : !pop ? rd_q : rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1;
    cnt_d = bus.flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) mem_q[wr_q] <= wdat;
      if (pop) last_q <= mem_q[rd_q];
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fpu_pack_pipe.sv
// tb_fpu_pack_pipe: directed and randomized checks of fpu_pack_pipe against a queue-based reference.
module tb_fpu_pack_pipe;
  localparam int FLEN = 64, LANES = 2, DEPTH = 2, DW = LANES * FLEN;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0, failures = 0;
  logic [DW:0] q[$];
  logic [DW:0] lastp = '0;
  always #5 clk = ~clk;
  fpu_pack_pipe_if #(.LANES(LANES), .FLEN(FLEN)) bus ();
  fpu_pack_pipe #(.FLEN(FLEN), .FPSIZES(3), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  function automatic logic [63:0] lane_m(input logic [63:0] u, input logic [1:0] fmt, input logic box);
    logic s; logic [10:0] e; logic [51:0] f; logic [7:0] e8; logic [22:0] f8;
    s = u[63];
    if (fmt == 2'b01) begin
      e = u[62:52]; f = u[51:0];
`ifdef FPU_PACK_NANCANON_EN
      if (&e && |f) begin s = 1'b0; f = 52'h8000000000000; end
`endif
      return {s, e, f};
    end
    e8 = {u[62], u[58:52]}; f8 = u[51:29];
`ifdef FPU_PACK_NANCANON_EN
    if (&e8 && |f8) begin s = 1'b0; f8 = 23'h400000; end
`endif
    return {{32{box}}, s, e8, f8};
  endfunction

  function automatic logic [DW:0] beat_m(input logic [DW-1:0] u, input logic [1:0] fmt, input logic box);
    if (fmt[1]) return {1'b1, {DW{1'b0}}};
    return {1'b0, lane_m(u[127:64], fmt, box), lane_m(u[63:0], fmt, box)};
  endfunction

  function automatic logic [63:0] rnd_lane();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) v[62:52] = 11'h7FF;
    if ($urandom_range(0, 7) == 0) v[62:29] = '1;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] u, input logic [1:0] fmt, input logic box);
    bus.in_valid = 1'b1; bus.unpacked = u; bus.fmt = fmt; bus.box_en = box;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks += 4;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    if (bus.pkd !== '0) begin failures++; $display("FAIL reset_packed got=%h want=0", bus.pkd); end
    if (bus.fmt_err !== 1'b0) begin failures++; $display("FAIL reset_fmt_err got=%b want=0", bus.fmt_err); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_single();
    logic [1:0] fm[3] = '{2'b00, 2'b00, 2'b01};
    logic bx[3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] l0[3] = '{64'hFFFFFFFF3F800000, 64'h000000003F800000, 64'h3FF0000000000000};
    logic [DW-1:0] u;
    logic [DW:0] exp_b;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      u = {64'hC000000000000000, 64'h3FF0000000000000};
      exp_b = beat_m(u, fm[i], bx[i]);
      bus.in_valid = 1'b1; bus.unpacked = u; bus.fmt = fm[i]; bus.box_en = bx[i];
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass[%0d] got=%b want=0", i, bus.out_valid); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks += 3;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d] got=%b want=1", i, bus.out_valid); end
      if (bus.pkd[63:0] !== l0[i]) begin failures++; $display("FAIL single_lane0[%0d] got=%h want=%h", i, bus.pkd[63:0], l0[i]); end
      if ({bus.fmt_err, bus.pkd} !== exp_b) begin failures++; $display("FAIL single_beat[%0d] got=%h want=%h", i, {bus.fmt_err, bus.pkd}, exp_b); end
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      lastp = exp_b;
      checks += 2;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_empty[%0d] got=%b want=0", i, bus.out_valid); end
      if ({bus.fmt_err, bus.pkd} !== exp_b) begin failures++; $display("FAIL single_hold[%0d] got=%h want=%h", i, {bus.fmt_err, bus.pkd}, exp_b); end
    end
  endtask

  task automatic test_fmt_err();
    logic [DW-1:0] u;
    bus.out_ready = 1'b1;
    push_beat({rnd_lane(), rnd_lane()}, 2'b10, 1'b1);
    checks += 2;
    if (bus.fmt_err !== 1'b1) begin failures++; $display("FAIL fmterr_set got=%b want=1", bus.fmt_err); end
    if (bus.pkd !== '0) begin failures++; $display("FAIL fmterr_zero got=%h want=0", bus.pkd); end
    u = {rnd_lane(), rnd_lane()};
    push_beat(u, 2'b00, 1'b1);
    checks += 2;
    if (bus.fmt_err !== 1'b0) begin failures++; $display("FAIL fmterr_clear got=%b want=0", bus.fmt_err); end
    if ({bus.fmt_err, bus.pkd} !== beat_m(u, 2'b00, 1'b1)) begin failures++; $display("FAIL fmterr_next got=%h want=%h", {bus.fmt_err, bus.pkd}, beat_m(u, 2'b00, 1'b1)); end
    cyc();
    lastp = beat_m(u, 2'b00, 1'b1);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_snan();
    logic [63:0] w0, w1;
`ifdef FPU_PACK_NANCANON_EN
    w0 = 64'hFFFFFFFF7FC00000; w1 = 64'h7FF8000000000000;
`else
    w0 = 64'hFFFFFFFFFFA00000; w1 = 64'hFFF4000000000000;
`endif
    bus.out_ready = 1'b1;
    push_beat({2{64'hFFF4000000000000}}, 2'b00, 1'b1);
    checks++;
    if (bus.pkd !== {w0, w0}) begin failures++; $display("FAIL snan_single got=%h want=%h", bus.pkd, {w0, w0}); end
    push_beat({2{64'hFFF4000000000000}}, 2'b01, 1'b0);
    checks++;
    if (bus.pkd !== {w1, w1}) begin failures++; $display("FAIL snan_double got=%h want=%h", bus.pkd, {w1, w1}); end
    cyc();
    lastp = {1'b0, w1, w1};
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] b[4];
    logic [1:0] f[4];
    logic x[4];
    for (int i = 0; i < 4; i++) begin
      b[i] = {rnd_lane(), rnd_lane()}; f[i] = 2'($urandom_range(0, 1)); x[i] = 1'($urandom_range(0, 1));
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.unpacked = b[i]; bus.fmt = f[i]; bus.box_en = x[i];
      #1;
      checks++;
      if (bus.in_ready !== (i < 2)) begin failures++; $display("FAIL bp_ready[%0d] got=%b want=%b", i, bus.in_ready, i < 2); end
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.fmt_err, bus.pkd} !== beat_m(b[0], f[0], x[0])) begin failures++; $display("FAIL bp_head0 got=%h want=%h", {bus.fmt_err, bus.pkd}, beat_m(b[0], f[0], x[0])); end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_full_pop_ready got=%b want=1", bus.in_ready); end
    for (int i = 2; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.unpacked = b[i]; bus.fmt = f[i]; bus.box_en = x[i];
      cyc();
      bus.out_ready = 1'b0;
      #1;
      checks += 2;
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_still_full[%0d] got=%b want=0", i, bus.in_ready); end
      if ({bus.fmt_err, bus.pkd} !== beat_m(b[i-1], f[i-1], x[i-1])) begin failures++; $display("FAIL bp_order[%0d] got=%h want=%h", i, {bus.fmt_err, bus.pkd}, beat_m(b[i-1], f[i-1], x[i-1])); end
      bus.out_ready = 1'b1;
    end
    bus.in_valid = 1'b0;
    cyc();
    checks++;
    if ({bus.out_valid, bus.fmt_err, bus.pkd} !== {1'b1, beat_m(b[3], f[3], x[3])}) begin failures++; $display("FAIL bp_last got=%h want=%h", {bus.out_valid, bus.fmt_err, bus.pkd}, {1'b1, beat_m(b[3], f[3], x[3])}); end
    cyc();
    lastp = beat_m(b[3], f[3], x[3]);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] u;
    bus.out_ready = 1'b0;
    push_beat({rnd_lane(), rnd_lane()}, 2'b00, 1'b1);
    push_beat({rnd_lane(), rnd_lane()}, 2'b01, 1'b0);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready_low got=%b want=0", bus.in_ready); end
    cyc();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b want=0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b want=1", bus.in_ready); end
    if ({bus.fmt_err, bus.pkd} !== lastp) begin failures++; $display("FAIL flush_hold got=%h want=%h", {bus.fmt_err, bus.pkd}, lastp); end
    u = {rnd_lane(), rnd_lane()};
    push_beat(u, 2'b00, 1'b0);
    checks++;
    if ({bus.out_valid, bus.fmt_err, bus.pkd} !== {1'b1, beat_m(u, 2'b00, 1'b0)}) begin failures++; $display("FAIL flush_refill got=%h want=%h", {bus.out_valid, bus.fmt_err, bus.pkd}, {1'b1, beat_m(u, 2'b00, 1'b0)}); end
    bus.out_ready = 1'b1;
    cyc();
    lastp = beat_m(u, 2'b00, 1'b0);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic exp_rdy, do_push, do_pop;
    logic [DW:0] head;
    q.delete();
    for (int n = 0; n < 600; n++) begin
      head = q.size() != 0 ? q[0] : lastp;
      checks += 2;
      if (bus.out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid[%0d] got=%b want=%b", n, bus.out_valid, q.size() != 0); end
      if ({bus.fmt_err, bus.pkd} !== head) begin failures++; $display("FAIL rnd_head[%0d] got=%h want=%h", n, {bus.fmt_err, bus.pkd}, head); end
      bus.in_valid  = $urandom_range(0, 2) != 0;
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.flush     = $urandom_range(0, 19) == 0;
      bus.unpacked  = {rnd_lane(), rnd_lane()};
      bus.fmt       = 2'($urandom_range(0, 3));
      bus.box_en    = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = !bus.flush && (q.size() < DEPTH || bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready[%0d] got=%b want=%b", n, bus.in_ready, exp_rdy); end
      do_push = bus.in_valid && exp_rdy;
      do_pop  = !bus.flush && bus.out_ready && q.size() != 0;
      head = beat_m(bus.unpacked, bus.fmt, bus.box_en);
      if (bus.flush) q.delete();
      else begin
        if (do_pop) lastp = q.pop_front();
        if (do_push) q.push_back(head);
      end
      cyc();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    push_beat({2{64'h3FF0000000000000}}, 2'b00, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%b want=1", bus.out_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b want=0", bus.out_valid); end
    if (bus.pkd !== '0) begin failures++; $display("FAIL areset_packed got=%h want=0", bus.pkd); end
    if (bus.fmt_err !== 1'b0) begin failures++; $display("FAIL areset_err got=%b want=0", bus.fmt_err); end
    cyc();
    #2 reset_n = 1'b1;
    q.delete();
    lastp = '0;
    cyc();
    checks++;
    if ({bus.out_valid, bus.fmt_err, bus.pkd} !== '0) begin failures++; $display("FAIL areset_after got=%h want=0", {bus.out_valid, bus.fmt_err, bus.pkd}); end
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.unpacked = '0; bus.fmt = 2'b00;
    bus.box_en = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_single();
    test_fmt_err();
    test_snan();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
